// File: rtl/disparity_pixel_filter_pkg.sv
// Shared constants, derived widths and the output pixel record for the disparity filter.
// Downstream consumers import disp_pix_t from here.
package disp_filter_pkg;

   localparam int unsigned DECIMATE   = 2;
   localparam int unsigned OUT_W      = 120;
   localparam int unsigned OUT_H      = 24;
   localparam int unsigned DISP_BITS  = 5;
   localparam int unsigned XOR_THRESH = 1;
   localparam int unsigned MAX_FILL   = 4;

   localparam int unsigned COL_W  = $clog2(OUT_W);
   localparam int unsigned ROW_W  = $clog2(OUT_H);
   localparam int unsigned ACC_W  = $clog2(DECIMATE * DECIMATE + 1);
   localparam int unsigned PC_W   = $clog2(DECIMATE + 1);
   localparam int unsigned BEAT_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
   localparam int unsigned HOLE_W = $clog2(MAX_FILL + 1);

   typedef struct packed {
      logic [7:0] disp;
      logic       ok;
      logic       filled;
      logic       sof;
      logic       eol;
   } disp_pix_t;

endpackage

// File: rtl/disparity_pixel_filter_if.sv
// Pixel-in / disparity-out stream bundle. master is the upstream/stimulus side,
// slave is the filter itself.
interface disparity_pixel_filter_if;
   import disp_filter_pkg::*;

   logic [DECIMATE-1:0] pix_data;
   logic                pix_valid;
   logic [7:0]          conf_in;
   logic [7:0]          disp_in;
   logic [7:0]          conf_thresh;

   logic [7:0]          out_disp;
   logic                out_ok;
   logic                out_filled;
   logic                out_valid;
   logic                out_sof;
   logic                out_eol;

   modport master (
      output pix_data, pix_valid, conf_in, disp_in, conf_thresh,
      input  out_disp, out_ok, out_filled, out_valid, out_sof, out_eol
   );

   modport slave (
      input  pix_data, pix_valid, conf_in, disp_in, conf_thresh,
      output out_disp, out_ok, out_filled, out_valid, out_sof, out_eol
   );

endinterface

// File: rtl/bit_popcount.sv
// Combinational population count of an N-bit vector.
module bit_popcount #(
   parameter  int unsigned N  = 2,
   localparam int unsigned CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  bits,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < int'(N); i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/disparity_pixel_filter.sv
// Groups DECIMATE mask beats into one pixel, qualifies its disparity on mismatch count and
// confidence, fills short in-row holes with the last good value, and emits a raster stream.
module disparity_pixel_filter
   import disp_filter_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   disparity_pixel_filter_if.slave  bus
);

   logic [PC_W-1:0] beat_pop;

   bit_popcount #(
      .N (DECIMATE)
   ) u_popcount (
      .bits  (bus.pix_data),
      .count (beat_pop)
   );

   logic [BEAT_W-1:0]    beat_cnt;
   logic [ACC_W-1:0]     acc;
   logic [7:0]           conf_q;
   logic [7:0]           thresh_q;
   logic [DISP_BITS-1:0] disp_q;
   logic [COL_W-1:0]     col;
   logic [ROW_W-1:0]     row;
   logic [HOLE_W-1:0]    hole_len;
   logic [DISP_BITS-1:0] last_good;
   logic                 last_good_vld;
   disp_pix_t            out_q;
   logic                 out_valid_q;

   logic                 first_beat;
   logic                 last_beat;
   logic [7:0]           grp_conf;
   logic [7:0]           grp_thresh;
   logic [DISP_BITS-1:0] grp_disp;
   logic [ACC_W-1:0]     total;
   logic                 pix_ok;
   logic                 fillable;
   disp_pix_t            pix_d;

   logic unused_disp;
   assign unused_disp = ^bus.disp_in[7:DISP_BITS];

   // On beat 0 the group fields come straight from the inputs, so DECIMATE=1 also works.
   always_comb begin
      first_beat = (beat_cnt == '0);
      last_beat  = (beat_cnt == BEAT_W'(DECIMATE - 1));
      grp_conf   = first_beat ? bus.conf_in                  : conf_q;
      grp_thresh = first_beat ? bus.conf_thresh              : thresh_q;
      grp_disp   = first_beat ? bus.disp_in[DISP_BITS-1:0]   : disp_q;
      total      = (first_beat ? '0 : acc) + ACC_W'(beat_pop);
      pix_ok     = (32'(total) <= XOR_THRESH) && (grp_conf >= grp_thresh);
      fillable   = last_good_vld && (hole_len < HOLE_W'(MAX_FILL));

      pix_d.sof    = (row == '0) && (col == '0);
      pix_d.eol    = (col == COL_W'(OUT_W - 1));
      pix_d.ok     = pix_ok;
      pix_d.filled = !pix_ok && fillable;
      if (pix_ok) begin
         pix_d.disp = 8'(grp_disp);
      end else if (fillable) begin
         pix_d.disp = 8'(last_good);
      end else begin
         pix_d.disp = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt      <= '0;
         acc           <= '0;
         conf_q        <= '0;
         thresh_q      <= '0;
         disp_q        <= '0;
         col           <= '0;
         row           <= '0;
         hole_len      <= '0;
         last_good     <= '0;
         last_good_vld <= 1'b0;
         out_q         <= '0;
         out_valid_q   <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (bus.pix_valid) begin
            if (first_beat) begin
               conf_q   <= bus.conf_in;
               thresh_q <= bus.conf_thresh;
               disp_q   <= bus.disp_in[DISP_BITS-1:0];
            end
            acc <= total;
            if (last_beat) begin
               beat_cnt    <= '0;
               out_valid_q <= 1'b1;
               out_q       <= pix_d;
               // Fill history never survives a row boundary.
               if (pix_d.eol) begin
                  last_good_vld <= 1'b0;
                  hole_len      <= '0;
               end else if (pix_ok) begin
                  last_good     <= grp_disp;
                  last_good_vld <= 1'b1;
                  hole_len      <= '0;
               end else if (hole_len < HOLE_W'(MAX_FILL)) begin
                  hole_len <= hole_len + HOLE_W'(1);
               end

               if (pix_d.eol) begin
                  col <= '0;
                  row <= (row == ROW_W'(OUT_H - 1)) ? '0 : row + ROW_W'(1);
               end else begin
                  col <= col + COL_W'(1);
               end
            end else begin
               beat_cnt <= beat_cnt + BEAT_W'(1);
            end
         end
      end
   end

   assign bus.out_disp   = out_q.disp;
   assign bus.out_ok     = out_q.ok;
   assign bus.out_filled = out_q.filled;
   assign bus.out_sof    = out_q.sof;
   assign bus.out_eol    = out_q.eol;
   assign bus.out_valid  = out_valid_q;

endmodule
